// File: rtl/voice_scheduler_if.sv
// Bundle between voice_scheduler and its environment: voice inputs,
// shared-lookup handshake, and the per-voice tone outputs.
interface voice_scheduler_if #(
    parameter int NVOICES = 4,
    parameter int DIVW    = 19
);
    localparam int SW = $clog2(NVOICES);
    localparam int MW = $clog2(NVOICES + 1);

    logic [4*NVOICES-1:0] voice_note;
    logic [3*NVOICES-1:0] voice_octave;
    logic [3:0]           lu_note;
    logic [2:0]           lu_octave;
    logic [DIVW-1:0]      lu_divider;
    logic [SW-1:0]        slot;
    logic [NVOICES-1:0]   wave;
    logic [NVOICES-1:0]   active;
    logic [MW-1:0]        mix;

    modport master (
        input  voice_note, voice_octave, lu_divider,
        output lu_note, lu_octave, slot, wave, active, mix
    );

    modport slave (
        output voice_note, voice_octave, lu_divider,
        input  lu_note, lu_octave, slot, wave, active, mix
    );
endinterface

// File: rtl/voice_scheduler.sv
// Round-robin tone generator sharing one note-to-divider lookup across voices.
// Define VOICE_MIX_EN to get a registered population count of the waves on mix.
module voice_scheduler #(
    parameter int NVOICES = 4,
    parameter int DIVW    = 19
) (
    input  logic          clk,
    input  logic          rst,
    voice_scheduler_if.master vif
);
    localparam int SW = $clog2(NVOICES);
    localparam int MW = $clog2(NVOICES + 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NVOICES - 1);

    logic [SW-1:0]      slot_q;
    logic [NVOICES-1:0] wave_q;
    logic [NVOICES-1:0] active_q;
    logic [DIVW-1:0]    div_reg [NVOICES];
    logic [DIVW-1:0]    cnt     [NVOICES];
    logic [DIVW-1:0]    new_div;
    logic               note_ok;

    function automatic logic note_valid(input logic [3:0] n);
        return (n != 4'd0) && (n <= 4'd13);
    endfunction

    // A half-period below two cycles cannot be produced; clamp to the minimum.
    function automatic logic [DIVW-1:0] clamp_div(input logic [DIVW-1:0] d);
        return (d < DIVW'(2)) ? DIVW'(2) : d;
    endfunction

    assign vif.lu_note   = vif.voice_note[4*int'(slot_q) +: 4];
    assign vif.lu_octave = vif.voice_octave[3*int'(slot_q) +: 3];

    always_comb begin
        note_ok = note_valid(vif.lu_note);
        new_div = clamp_div(vif.lu_divider);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q   <= '0;
            wave_q   <= '0;
            active_q <= '0;
            for (int i = 0; i < NVOICES; i++) begin
                div_reg[i] <= '0;
                cnt[i]     <= '0;
            end
        end else begin
            slot_q <= (slot_q == LAST_SLOT) ? '0 : slot_q + SW'(1);
            for (int i = 0; i < NVOICES; i++) begin
                // Capture at this voice's slot takes priority over its counter.
                if (slot_q == SW'(i) && !note_ok) begin
                    active_q[i] <= 1'b0;
                    wave_q[i]   <= 1'b0;
                    div_reg[i]  <= '0;
                    cnt[i]      <= '0;
                end else if (slot_q == SW'(i) && !active_q[i]) begin
                    active_q[i] <= 1'b1;
                    wave_q[i]   <= 1'b0;
                    div_reg[i]  <= new_div;
                    cnt[i]      <= new_div - DIVW'(1);
                end else if (slot_q == SW'(i) && new_div != div_reg[i]) begin
                    div_reg[i]  <= new_div;
                    cnt[i]      <= new_div - DIVW'(1);
                end else if (active_q[i]) begin
                    if (cnt[i] == '0) begin
                        wave_q[i] <= ~wave_q[i];
                        cnt[i]    <= div_reg[i] - DIVW'(1);
                    end else begin
                        cnt[i]    <= cnt[i] - DIVW'(1);
                    end
                end
            end
        end
    end

    assign vif.slot   = slot_q;
    assign vif.wave   = wave_q;
    assign vif.active = active_q;

`ifdef VOICE_MIX_EN
    logic [MW-1:0] mix_p1;

    function automatic logic [MW-1:0] popcount(input logic [NVOICES-1:0] w);
        logic [MW-1:0] sum;
        sum = '0;
        for (int k = 0; k < NVOICES; k++) begin
            sum = sum + MW'(w[k]);
        end
        return sum;
    endfunction

    // Stage p1: mix lags wave by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mix_p1 <= '0;
        end else begin
            mix_p1 <= popcount(wave_q);
        end
    end

    assign vif.mix = mix_p1;
`else
    assign vif.mix = '0;
`endif
endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: expectations are queued per cycle and
// a negedge monitor checks them against the DUT outputs.
module tb_voice_scheduler;
    localparam int NV = 4;
    localparam int DW = 19;

    typedef struct {
        int    cyc;
        int    kind;
        int    idx;
        int    val;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   c0 = 0;
    exp_t sbq[$];

    voice_scheduler_if #(.NVOICES(NV), .DIVW(DW)) vif ();

    voice_scheduler #(.NVOICES(NV), .DIVW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .vif (vif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] lookup(input logic [3:0] n, input logic [2:0] o);
        case ({n, o})
            {4'd10, 3'd4}: return 19'd13636;
            {4'd1,  3'd7}: return 19'd2866;
            {4'd5,  3'd7}: return 19'd2275;
            {4'd8,  3'd7}: return 19'd1913;
            {4'd9,  3'd7}: return 19'd1805;
            {4'd13, 3'd7}: return 19'd1433;
            {4'd2,  3'd0}: return 19'd0;
            {4'd3,  3'd0}: return 19'd1;
            default:       return 19'd1000;
        endcase
    endfunction

    always_comb vif.lu_divider = lookup(vif.lu_note, vif.lu_octave);

    function automatic int xm(input int v);
`ifdef VOICE_MIX_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic restart();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        c0 = cyc;
    endtask

    task automatic set_voice(input int v, input int n, input int o);
        vif.voice_note[v*4 +: 4]   = 4'(n);
        vif.voice_octave[v*3 +: 3] = 3'(o);
    endtask

    // kind: 0 slot, 1 wave bit, 2 active bit, 3 mix, 4 wave vec, 5 active vec, 6 lu_note, 7 lu_octave
    task automatic expect_at(input int c, input int kind, input int idx, input int val, input string name);
        exp_t e;
        e.cyc = c; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int k = sbq.size() - 1; k >= 0; k--) begin
            if (sbq[k].cyc == cyc) begin
                int act;
                case (sbq[k].kind)
                    0:       act = int'(vif.slot);
                    1:       act = int'(vif.wave[sbq[k].idx]);
                    2:       act = int'(vif.active[sbq[k].idx]);
                    3:       act = int'(vif.mix);
                    4:       act = int'(vif.wave);
                    5:       act = int'(vif.active);
                    6:       act = int'(vif.lu_note);
                    default: act = int'(vif.lu_octave);
                endcase
                total++;
                if (act != sbq[k].val) begin
                    bad++;
                    $display("FAIL %s at cycle %0d: got %0d want %0d",
                             sbq[k].name, cyc - c0, act, sbq[k].val);
                end
                sbq.delete(k);
            end
        end
    end

    initial begin
        vif.voice_note   = '0;
        vif.voice_octave = '0;

        // Reset and idle run
        tick(2);
        total++;
        if (vif.slot !== '0 || vif.wave !== '0 || vif.active !== '0 || vif.mix !== '0) begin
            bad++;
            $display("FAIL direct_rst: slot=%0d wave=%0b active=%0b mix=%0d",
                     vif.slot, vif.wave, vif.active, vif.mix);
        end
        expect_at(cyc, 4, 0, 0, "rst_wave");
        expect_at(cyc, 5, 0, 0, "rst_active");
        expect_at(cyc, 0, 0, 0, "rst_slot");
        expect_at(cyc, 3, 0, 0, "rst_mix");
        rst = 1'b0;
        c0 = cyc;
        for (int k = 0; k < 8; k++) expect_at(c0 + k, 0, 0, k % NV, $sformatf("idle_slot%0d", k));
        expect_at(c0 + 99, 4, 0, 0, "idle_wave");
        expect_at(c0 + 99, 5, 0, 0, "idle_active");
        expect_at(c0 + 99, 3, 0, 0, "idle_mix");
        tick(100);
        total++;
        if (vif.wave !== '0 || vif.active !== '0) begin
            bad++;
            $display("FAIL direct_idle: wave=%0b active=%0b", vif.wave, vif.active);
        end

        // Single voice, note 10 octave 4
        restart();
        set_voice(0, 10, 4);
        expect_at(c0,         2, 0, 0, "a440_active_pre");
        expect_at(c0 + 1,     2, 0, 1, "a440_active");
        expect_at(c0 + 13636, 1, 0, 0, "a440_pre_rise");
        expect_at(c0 + 13637, 1, 0, 1, "a440_rise");
        expect_at(c0 + 13637, 3, 0, xm(0), "a440_mix0");
        expect_at(c0 + 13638, 3, 0, xm(1), "a440_mix1");
        expect_at(c0 + 27272, 1, 0, 1, "a440_pre_fall");
        expect_at(c0 + 27273, 1, 0, 0, "a440_fall");
        tick(27280);

        // Chord C/E/G/C octave 7, then retune, note-off/on and mid-run reset
        set_voice(0, 1, 7);
        set_voice(1, 5, 7);
        set_voice(2, 8, 7);
        set_voice(3, 13, 7);
        restart();
        expect_at(c0 + 1, 6, 0, 5, "lu_note_v1");
        expect_at(c0 + 1, 7, 0, 7, "lu_oct_v1");
        expect_at(c0 + 3, 5, 0, 7, "chord_active3");
        expect_at(c0 + 4, 5, 0, 15, "chord_active4");
        expect_at(c0 + 2866, 1, 0, 0, "v0_pre_rise");
        expect_at(c0 + 2867, 1, 0, 1, "v0_rise");
        expect_at(c0 + 5732, 1, 0, 1, "v0_pre_fall");
        expect_at(c0 + 5733, 1, 0, 0, "v0_fall");
        expect_at(c0 + 2276, 1, 1, 0, "v1_pre_rise");
        expect_at(c0 + 2277, 1, 1, 1, "v1_rise");
        expect_at(c0 + 1915, 1, 2, 0, "v2_pre_rise");
        expect_at(c0 + 1916, 1, 2, 1, "v2_rise");
        expect_at(c0 + 1436, 1, 3, 0, "v3_pre_rise");
        expect_at(c0 + 1437, 1, 3, 1, "v3_rise");
        expect_at(c0 + 2869, 1, 3, 1, "v3_pre_fall");
        expect_at(c0 + 2870, 1, 3, 0, "v3_fall");
        expect_at(c0 + 2867, 4, 0, 15, "chord_all_high");
        expect_at(c0 + 2868, 3, 0, xm(4), "chord_mix4");
        expect_at(c0 + 2870, 4, 0, 7, "chord_three_high");
        expect_at(c0 + 2871, 3, 0, xm(3), "chord_mix3");
        expect_at(c0 + 2003, 1, 2, 1, "retune_hold");
        expect_at(c0 + 3807, 1, 2, 1, "retune_pre_fall");
        expect_at(c0 + 3808, 1, 2, 0, "retune_fall");
        expect_at(c0 + 5612, 1, 2, 0, "retune_pre_rise");
        expect_at(c0 + 5613, 1, 2, 1, "retune_rise");
        expect_at(c0 + 3001, 1, 1, 1, "off_wave_pre");
        expect_at(c0 + 3001, 2, 1, 1, "off_active_pre");
        expect_at(c0 + 3002, 1, 1, 0, "off_wave");
        expect_at(c0 + 3002, 2, 1, 0, "off_active");
        expect_at(c0 + 3500, 1, 1, 0, "off_wave_held");
        expect_at(c0 + 4002, 2, 1, 1, "on_active");
        expect_at(c0 + 4002, 1, 1, 0, "on_wave_low");
        expect_at(c0 + 6276, 1, 1, 0, "on_pre_rise");
        expect_at(c0 + 6277, 1, 1, 1, "on_rise");
        expect_at(c0 + 6400, 5, 0, 15, "prerst_active");
        expect_at(c0 + 6401, 4, 0, 0, "midrst_wave");
        expect_at(c0 + 6401, 5, 0, 0, "midrst_active");
        expect_at(c0 + 6401, 0, 0, 0, "midrst_slot");
        expect_at(c0 + 6401, 3, 0, 0, "midrst_mix");
        expect_at(c0 + 6402, 0, 0, 1, "postrst_slot");
        expect_at(c0 + 6402, 5, 0, 1, "postrst_active1");
        expect_at(c0 + 6405, 5, 0, 15, "postrst_active4");
        wait_until(c0 + 2000);
        set_voice(2, 9, 7);
        wait_until(c0 + 3000);
        set_voice(1, 15, 7);
        wait_until(c0 + 4000);
        set_voice(1, 5, 7);
        wait_until(c0 + 6400);
        rst = 1'b1;
        tick(1);
        total++;
        if (vif.slot !== '0 || vif.wave !== '0 || vif.active !== '0) begin
            bad++;
            $display("FAIL direct_midrst: slot=%0d wave=%0b active=%0b",
                     vif.slot, vif.wave, vif.active);
        end
        rst = 1'b0;
        tick(10);

        // Degenerate dividers 0 and 1 clamp to 2; code 14 is off
        set_voice(0, 2, 0);
        set_voice(1, 3, 0);
        set_voice(2, 0, 0);
        set_voice(3, 14, 7);
        restart();
        expect_at(c0 + 2,   1, 0, 0, "clamp0_pre_rise");
        expect_at(c0 + 3,   1, 0, 1, "clamp0_rise");
        expect_at(c0 + 4,   1, 0, 1, "clamp0_high");
        expect_at(c0 + 5,   1, 0, 0, "clamp0_fall");
        expect_at(c0 + 101, 1, 0, 0, "clamp0_late_low");
        expect_at(c0 + 103, 1, 0, 1, "clamp0_late_high");
        expect_at(c0 + 3,   1, 1, 0, "clamp1_pre_rise");
        expect_at(c0 + 4,   1, 1, 1, "clamp1_rise");
        expect_at(c0 + 5,   1, 1, 1, "clamp1_high");
        expect_at(c0 + 6,   1, 1, 0, "clamp1_fall");
        expect_at(c0 + 5,   5, 0, 3, "clamp_active");
        tick(110);

        for (int k = 0; k < 10 && sbq.size() != 0; k++) tick(1);
        while (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s unchecked: got none want %0d at cycle %0d",
                     sbq[0].name, sbq[0].val, sbq[0].cyc);
            sbq.delete(0);
        end
        if (bad == 0) $display("PASS");
        else $display("FAIL: %0d mismatches", bad);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Time-multiplexed tone generator that shares one combinational note-to-divider lookup among `NVOICES` independent voices. A round-robin slot counter presents each voice's note/octave to the shared lookup, and captures the returned half-period divider into that voice's register. Each voice then runs its own down-counter to produce a square wave. The block sits between the key/sequencer front end and the audio mixer/PWM stage.

## Interface
- `NVOICES`, 4: number of voices, 2..8.
- `DIVW`, 19: divider/counter width; matches lookup output.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `voice_note` in 4*NVOICES: per-voice note code; voice i at bits [4i+3:4i]. Code 0 or 14..15 means off.
- `voice_octave` in 3*NVOICES: per-voice octave; voice i at bits [3i+2:3i].
- `lu_note` out 4: note presented to the shared lookup.
- `lu_octave` out 3: octave presented to the shared lookup.
- `lu_divider` in DIVW: combinational lookup result for `lu_note`/`lu_octave`.
- `slot` out clog2(NVOICES): voice currently being serviced.
- `wave` out NVOICES: square-wave output per voice.
- `active` out NVOICES: voice i has a valid note and a loaded divider.
- `mix` out clog2(NVOICES+1): count of `wave` bits high. Real only with `VOICE_MIX_EN`.

## Operation
- Slot counter: increments every cycle and wraps NVOICES-1 → 0. `lu_note`/`lu_octave` are combinational from voice `slot`'s inputs.
- Capture, at slot i, same cycle:
  - Note valid (1..13): `div_reg[i] <= lu_divider`, `active[i] <= 1`.
  - Note invalid: `active[i] <= 0`, `div_reg[i] <= 0`.
- Divider 0 or 1 returned for a valid note: treated as 2 (minimum half-period).
- Per-voice counter `cnt[i]`, DIVW bits, only while `active[i]`:
  - `cnt[i]==0`: toggle `wave[i]`, load `div_reg[i]-1`.
  - Otherwise decrement.
  - Half period = `div_reg[i]` cycles; full period = 2×divider.
- Retune: if the captured divider differs from the held `div_reg[i]` while active, load `cnt[i] <= new-1` in that cycle and leave `wave[i]` unchanged. Phase restarts; no glitch shorter than one cycle.
- Note-on: capture with `active[i]` previously 0 sets `cnt[i] <= new-1`, `wave[i] <= 0`.
- Note-off capture: `wave[i] <= 0`, `cnt[i] <= 0`, held until re-activated.
- Input changes are sampled only at that voice's slot. Changes lasting under NVOICES cycles may be missed; this is by design.

## Timing
- Reset values: `slot`=0, `wave`=0, `active`=0, `mix`=0, all `div_reg`/`cnt`=0. `lu_*` then reflect voice 0 inputs.
- Reset asserted mid-operation overrides all updates that cycle.
- Note-change latency: 1..NVOICES cycles to capture. First `wave` toggle follows `divider` cycles after capture.
- After reset, voice i is first serviced at cycle i (cycle 0 = first cycle with `rst` low).
- Counter reload and capture for the same voice in one cycle: capture rule wins.
- `mix` is registered: one cycle behind `wave`.

## Configuration
- `VOICE_MIX_EN` defined:
  - `mix` is the registered population count of `wave`.
  - Reset value 0, range 0..NVOICES.
- `VOICE_MIX_EN` undefined:
  - No adder logic.
  - `mix` tied to 0.

## Test plan
- Reset, all notes 0, run 100 cycles → `slot` cycles 0,1,2,3,0…; `wave`=0, `active`=0, `mix`=0.
- Voice 0: note 10, octave 4, with the team `lookup_table` on the `lu_*` ports:
  - `active[0]`=1 by cycle 1.
  - `wave[0]` rises 13636 cycles after capture, then toggles every 13636 cycles.
- Voices 0–3 = C/E/G/C (1,5,8,13), octave 7:
  - Dividers captured 2866/2275/1913/1433.
  - Each `wave[i]` half-period is exact.
  - With `VOICE_MIX_EN`, `mix` equals the registered count of high waves.
- Voice 2 changes note 8 → 9 (octave 7) mid-period:
  - `div_reg[2]` becomes 1805 at its slot.
  - `cnt` reloads to 1804, `wave[2]` holds level, and the next edge comes 1805 cycles later.
- Voice 1 set to note 15 → at its slot `active[1]`=0 and `wave[1]`=0 on the next cycle, held low. Restoring note 5 restarts from `wave`=0.
- Assert `rst` for one cycle while all voices toggle → next cycle all outputs at reset values, and `slot`=0.
